// File: rtl/fifo_single_clock_reg_v4.sv
// Single-clock register-array FIFO with configurable width, depth and read mode.
// It provides almost-full/almost-empty thresholds, a synchronous flush, ovf/udf pulses and a sticky fail flag.
module fifo_single_clock_reg_v4 #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 8,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2,
  localparam int DEPTH_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               flush,
  input  logic               w_req,
  input  logic [WIDTH-1:0]   w_data,
  input  logic               r_req,
  output logic [WIDTH-1:0]   r_data,
  output logic               r_valid,
  output logic [DEPTH_W-1:0] cnt,
  output logic               empty,
  output logic               full,
  output logic               almost_full,
  output logic               almost_empty,
  output logic               ovf,
  output logic               udf,
  output logic               fail,
  input  logic               clr_fail
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [DEPTH_W-1:0] wptr_q, wptr_d;
  logic [DEPTH_W-1:0] rptr_q, rptr_d;
  logic [DEPTH_W-1:0] cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               udf_q, udf_d;
  logic               fail_q, fail_d;
  logic               empty_s, full_s;
  logic               wr_acc, rd_acc;

  assign empty_s = (cnt_q == '0);
  assign full_s  = (cnt_q == DEPTH_W'(DEPTH));

  // A write into a full FIFO is still accepted when a read frees a slot in the same cycle.
  always_comb begin
    rd_acc = r_req && !empty_s && !flush;
    wr_acc = w_req && (!full_s || r_req) && !flush;
    ovf_d  = w_req && full_s && !r_req && !flush;
    udf_d  = r_req && empty_s && !flush;
    wptr_d = flush ? '0 : wptr_q + {{(DEPTH_W-1){1'b0}}, wr_acc};
    rptr_d = flush ? '0 : rptr_q + {{(DEPTH_W-1){1'b0}}, rd_acc};
    cnt_d  = wptr_d - rptr_d;
    fail_d = fail_q;
    if (ovf_d || udf_d) begin
      fail_d = 1'b1;
    end else if (clr_fail) begin
      fail_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
      fail_q <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
      fail_q <= fail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wptr_q[AW-1:0]] <= w_data;
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Forced to zero while empty so reset and flush never expose stale memory.
    assign r_data  = empty_s ? '0 : mem_q[rptr_q[AW-1:0]];
    assign r_valid = !empty_s;
  end else begin : g_std
    logic [WIDTH-1:0] r_data_q;
    logic             r_valid_q;

    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        r_data_q  <= '0;
        r_valid_q <= 1'b0;
      end else begin
        r_valid_q <= rd_acc;
        if (rd_acc) begin
          r_data_q <= mem_q[rptr_q[AW-1:0]];
        end
      end
    end

    assign r_data  = r_data_q;
    assign r_valid = r_valid_q;
  end

  assign cnt          = cnt_q;
  assign empty        = empty_s;
  assign full         = full_s;
  assign almost_full  = (cnt_q >= DEPTH_W'(AF_LEVEL));
  assign almost_empty = (cnt_q <= DEPTH_W'(AE_LEVEL));
  assign ovf          = ovf_q;
  assign udf          = udf_q;
  assign fail         = fail_q;

endmodule

// File: tb/tb_fifo_single_clock_reg_v4.sv
// Directed bench for fifo_single_clock_reg_v4: a standard-read instance checked against a queue model
// and scoreboard, and a first-word-fall-through instance exercised alongside it.
module tb_fifo_single_clock_reg_v4;

  logic        clk = 1'b0;
  logic        nrst;

  logic        a_flush, a_w, a_r, a_clr;
  logic [31:0] a_wd, a_rd;
  logic        a_rv, a_empty, a_full, a_af, a_ae, a_ovf, a_udf, a_fail;
  logic [3:0]  a_cnt;

  logic        b_flush, b_w, b_r, b_clr;
  logic [31:0] b_wd, b_rd;
  logic        b_rv, b_empty, b_full, b_af, b_ae, b_ovf, b_udf, b_fail;
  logic [3:0]  b_cnt;

  int passed = 0;
  int total  = 0;

  logic [31:0] m[$];
  logic [31:0] sb[$];
  logic [31:0] last_rd = '0;
  logic        e_fail = 1'b0;
  logic        e_ovf = 1'b0;
  logic        e_udf = 1'b0;

  always #5 clk = ~clk;

  fifo_single_clock_reg_v4 #(.WIDTH(32), .DEPTH(8), .FWFT(0), .AF_LEVEL(6), .AE_LEVEL(2)) u_a (
    .clk(clk), .nrst(nrst), .flush(a_flush), .w_req(a_w), .w_data(a_wd), .r_req(a_r),
    .r_data(a_rd), .r_valid(a_rv), .cnt(a_cnt), .empty(a_empty), .full(a_full),
    .almost_full(a_af), .almost_empty(a_ae), .ovf(a_ovf), .udf(a_udf), .fail(a_fail),
    .clr_fail(a_clr)
  );

  fifo_single_clock_reg_v4 #(.WIDTH(32), .DEPTH(8), .FWFT(1), .AF_LEVEL(6), .AE_LEVEL(2)) u_b (
    .clk(clk), .nrst(nrst), .flush(b_flush), .w_req(b_w), .w_data(b_wd), .r_req(b_r),
    .r_data(b_rd), .r_valid(b_rv), .cnt(b_cnt), .empty(b_empty), .full(b_full),
    .almost_full(b_af), .almost_empty(b_ae), .ovf(b_ovf), .udf(b_udf), .fail(b_fail),
    .clr_fail(b_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_flags_a(input string tag);
    int n;
    n = m.size();
    chk({tag, " cnt"},   {28'd0, a_cnt}, n);
    chk({tag, " empty"}, {31'd0, a_empty}, {31'd0, n == 0});
    chk({tag, " full"},  {31'd0, a_full},  {31'd0, n == 8});
    chk({tag, " af"},    {31'd0, a_af},    {31'd0, n >= 6});
    chk({tag, " ae"},    {31'd0, a_ae},    {31'd0, n <= 2});
    chk({tag, " ovf"},   {31'd0, a_ovf},   {31'd0, e_ovf});
    chk({tag, " udf"},   {31'd0, a_udf},   {31'd0, e_udf});
    chk({tag, " fail"},  {31'd0, a_fail},  {31'd0, e_fail});
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " a_rd"},    a_rd, 32'd0);
    chk({tag, " a_rv"},    {31'd0, a_rv}, 32'd0);
    chk({tag, " a_cnt"},   {28'd0, a_cnt}, 32'd0);
    chk({tag, " a_empty"}, {31'd0, a_empty}, 32'd1);
    chk({tag, " a_full"},  {31'd0, a_full}, 32'd0);
    chk({tag, " a_af"},    {31'd0, a_af}, 32'd0);
    chk({tag, " a_ae"},    {31'd0, a_ae}, 32'd1);
    chk({tag, " a_ovf"},   {31'd0, a_ovf}, 32'd0);
    chk({tag, " a_udf"},   {31'd0, a_udf}, 32'd0);
    chk({tag, " a_fail"},  {31'd0, a_fail}, 32'd0);
    chk({tag, " b_rd"},    b_rd, 32'd0);
    chk({tag, " b_rv"},    {31'd0, b_rv}, 32'd0);
    chk({tag, " b_cnt"},   {28'd0, b_cnt}, 32'd0);
    chk({tag, " b_empty"}, {31'd0, b_empty}, 32'd1);
  endtask

  // One clock of the standard-read instance; the model predicts the outcome before the edge.
  task automatic cyc(input logic w, input logic [31:0] wd, input logic r,
                     input logic fl = 1'b0, input logic clr = 1'b0);
    logic m_full, m_empty, rd_ok, wr_ok;
    m_full  = (m.size() == 8);
    m_empty = (m.size() == 0);
    rd_ok   = r && !m_empty && !fl;
    wr_ok   = w && (!m_full || r) && !fl;
    e_ovf   = w && m_full && !r && !fl;
    e_udf   = r && m_empty && !fl;
    if (fl) begin
      m.delete();
    end else begin
      if (rd_ok) sb.push_back(m.pop_front());
      if (wr_ok) m.push_back(wd);
    end
    if (e_ovf || e_udf) e_fail = 1'b1;
    else if (clr) e_fail = 1'b0;
    a_w = w; a_wd = wd; a_r = r; a_flush = fl; a_clr = clr;
    @(posedge clk);
    #1;
    a_w = 1'b0; a_r = 1'b0; a_flush = 1'b0; a_clr = 1'b0;
    chk_flags_a("a");
    if (rd_ok) begin
      chk("a r_valid", {31'd0, a_rv}, 32'd1);
      last_rd = sb.pop_front();
      chk("a r_data", a_rd, last_rd);
    end else begin
      chk("a r_valid idle", {31'd0, a_rv}, 32'd0);
      chk("a r_data hold", a_rd, last_rd);
    end
  endtask

  task automatic bcyc(input logic w, input logic [31:0] wd, input logic r);
    b_w = w; b_wd = wd; b_r = r;
    @(posedge clk);
    #1;
    b_w = 1'b0; b_r = 1'b0;
  endtask

  initial begin
    nrst = 1'b0;
    a_flush = 1'b0; a_w = 1'b0; a_wd = '0; a_r = 1'b0; a_clr = 1'b0;
    b_flush = 1'b0; b_w = 1'b0; b_wd = '0; b_r = 1'b0; b_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    nrst = 1'b1;

    // First-word-fall-through: head visible without a read request.
    bcyc(1'b1, 32'hDEADBEEF, 1'b0);
    chk("b empty after write", {31'd0, b_empty}, 32'd0);
    chk("b r_valid fwft", {31'd0, b_rv}, 32'd1);
    chk("b r_data fwft", b_rd, 32'hDEADBEEF);
    chk("b cnt 1", {28'd0, b_cnt}, 32'd1);
    bcyc(1'b1, 32'h12345678, 1'b0);
    chk("b head held", b_rd, 32'hDEADBEEF);
    chk("b cnt 2", {28'd0, b_cnt}, 32'd2);
    bcyc(1'b0, 32'd0, 1'b1);
    chk("b second head", b_rd, 32'h12345678);
    bcyc(1'b0, 32'd0, 1'b1);
    chk("b empty after pop", {31'd0, b_empty}, 32'd1);
    chk("b r_valid after pop", {31'd0, b_rv}, 32'd0);

    // Overfill: pushes 9 and 10 are rejected.
    for (int i = 0; i < 10; i++) cyc(1'b1, 32'h10000000 + i, 1'b0);
    // Overdrain: pops 9 and 10 are rejected and r_data holds.
    for (int i = 0; i < 10; i++) cyc(1'b0, 32'd0, 1'b1);

    // Full with simultaneous write and read.
    for (int i = 0; i < 8; i++) cyc(1'b1, 32'h10000000 + i, 1'b0);
    cyc(1'b1, 32'hA5A5A5A5, 1'b1);
    for (int i = 0; i < 8; i++) cyc(1'b0, 32'd0, 1'b1);
    chk("a drain last A5", last_rd, 32'hA5A5A5A5);

    // Interleaved traffic across pointer wrap, occupancy 0..3.
    for (int i = 0; i < 20; i++) cyc(1'b1, 32'h20000000 + i, i >= 3);
    for (int i = 0; i < 3; i++) cyc(1'b0, 32'd0, 1'b1);
    chk("a interleave last", last_rd, 32'h20000013);

    // Flush with fail still set from the overflow tests, then clear fail.
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h30000000 + i, 1'b0);
    cyc(1'b1, 32'h3FFFFFFF, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 7; i++) cyc(1'b1, 32'h40000000 + i, 1'b0);
    cyc(1'b1, 32'h40000007, 1'b1);
    cyc(1'b1, 32'h40000008, 1'b1);
    cyc(1'b1, 32'h40000009, 1'b0);
    cyc(1'b1, 32'h4000000A, 1'b0);
    bcyc(1'b1, 32'h55AA55AA, 1'b0);
    #3;
    nrst = 1'b0;
    #1;
    chk_reset("async reset");
    m.delete(); sb.delete(); last_rd = '0; e_fail = 1'b0; e_ovf = 1'b0; e_udf = 1'b0;
    @(posedge clk);
    #1;
    nrst = 1'b1;
    cyc(1'b1, 32'h50000000, 1'b0);
    cyc(1'b0, 32'd0, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
